arb_mux_reg: RTL



---
 rtl/arb_mux_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating multiplexer with a registered valid/ready output stage.
// Fixed-priority (RR=0) or round-robin (RR=1) grant; one item per cycle at full throughput.
module arb_mux_reg #(
  parameter  int W  = 16,
  parameter  int N  = 16,
  parameter  int RR = 0,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  output logic [IW-1:0]  out_idx,
  output logic           out_valid,
  input  logic           out_ready
);

  // Adds step to base modulo N; base < N and step <= N keep the sum within IW+1 bits.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW:0] step);
    logic [IW:0] sum;
    sum = {1'b0, base} + step;
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] start_s;
  logic [N-1:0]  grant_s;
  logic [IW-1:0] grant_idx_s;
  logic          found_s;
  logic          load_en_s;
  logic [W-1:0]  sel_data_s;

  logic [W-1:0]  out_data_r;
  logic [N-1:0]  out_sel_r;
  logic [IW-1:0] out_idx_r;
  logic          out_valid_r;

  assign load_en_s = !out_valid_r || out_ready;

  // Priority search start: rotation pointer in round-robin mode, channel 0 otherwise.
  always_comb begin
    start_s = {IW{1'b0}};
    if (RR == 1) begin
      start_s = ptr_r;
    end else begin
      start_s = {IW{1'b0}};
    end
  end

  // Linear priority chain: first requesting channel at or after start_s, modulo N.
  always_comb begin
    found_s     = 1'b0;
    grant_s     = {N{1'b0}};
    grant_idx_s = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (!found_s && in_valid[wrap_add(start_s, (IW+1)'(k))]) begin
        found_s     = 1'b1;
        grant_idx_s = wrap_add(start_s, (IW+1)'(k));
        grant_s[wrap_add(start_s, (IW+1)'(k))] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign sel_data_s = in_data[grant_idx_s*W +: W];

  // rst_n gating keeps in_ready low for the whole reset, even though load_en is high then.
  assign in_ready = (rst_n && load_en_s) ? grant_s : {N{1'b0}};

  // Output stage: load the winner, go empty when draining with no request, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {W{1'b0}};
      out_sel_r   <= {N{1'b0}};
      out_idx_r   <= {IW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (load_en_s) begin
      if (found_s) begin
        out_data_r  <= sel_data_s;
        out_sel_r   <= grant_s;
        out_idx_r   <= grant_idx_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Rotation pointer: moves one past the channel just transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IW{1'b0}};
    end else if ((RR == 1) && load_en_s && found_s) begin
      ptr_r <= wrap_add(grant_idx_s, (IW+1)'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;

endmodule
